// File: rtl/aes_host_if.sv
// rtl/aes_host_if.sv - byte-serial host front end for the AES-128 core
// Gathers key/block bytes into 128-bit words, starts the core, streams the result back.
module aes_host_if #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_encrypt,
  input  logic         cmd_newkey,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:7]   in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:7]   out_data,
  output logic [0:127] key_o,
  output logic [0:127] block_o,
  output logic         sel_cypher,
  output logic         key_change,
  output logic         core_start,
  input  logic         core_done,
  input  logic [0:127] core_result,
  output logic         busy,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_LOAD_BLK,
    S_START,
    S_WAIT,
    S_UNLOAD
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t         state;
  logic [3:0]     idx;
  logic [15:0]    wcnt;
  logic [15:0]    wcnt_nx;
  logic [0:127]   out_reg;
  logic [6:0]     bit_base;

  assign wcnt_nx  = wcnt + 16'd1;
  assign bit_base = {idx, 3'b000};

  // Handshake outputs decode straight from the state register.
  assign cmd_ready  = (state == S_IDLE);
  assign in_ready   = (state == S_LOAD_KEY) || (state == S_LOAD_BLK);
  assign core_start = (state == S_START);
  assign out_valid  = (state == S_UNLOAD);
  assign busy       = (state != S_IDLE);
  assign out_data   = out_reg[bit_base +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= 4'd0;
      wcnt       <= 16'd0;
      key_o      <= '0;
      block_o    <= '0;
      out_reg    <= '0;
      sel_cypher <= 1'b0;
      key_change <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            sel_cypher <= cmd_encrypt;
            key_change <= cmd_newkey;
            err        <= 1'b0;
            idx        <= 4'd0;
            state      <= cmd_newkey ? S_LOAD_KEY : S_LOAD_BLK;
          end
        end
        // idx rolls 15 -> 0 exactly when the state is left, so each new state starts at byte 0.
        S_LOAD_KEY: begin
          if (in_valid) begin
            key_o[bit_base +: 8] <= in_data;
            idx                  <= idx + 4'd1;
            if (idx == 4'd15) state <= S_LOAD_BLK;
          end
        end
        S_LOAD_BLK: begin
          if (in_valid) begin
            block_o[bit_base +: 8] <= in_data;
            idx                    <= idx + 4'd1;
            if (idx == 4'd15) state <= S_START;
          end
        end
        S_START: begin
          wcnt  <= 16'd0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          wcnt <= wcnt_nx;
          // A result arriving on the threshold cycle still wins over the timeout.
          if (core_done) begin
            out_reg <= core_result;
            idx     <= 4'd0;
            state   <= S_UNLOAD;
          end else if (wcnt_nx == WAIT_LAST) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_UNLOAD: begin
          if (out_ready) begin
            idx <= idx + 4'd1;
            if (idx == 4'd15) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_host_if.md
# aes_host_if

Byte-serial host front end for the AES-128 core. It accepts a command, then a 16-byte key (optional) and a 16-byte data block over valid/ready byte streams, and presents them as 128-bit words to the core. It starts the core with a one-cycle pulse and captures the 128-bit result when the core reports done. It then streams the result back out byte by byte. It sits between the external host bus and the core's main FSM/datapath, driving the FSM's cipher-select and key-change inputs.

## Interface
Parameters:
- TIMEOUT, default 64: maximum number of cycles spent in WAIT before an error is raised; legal range 2..65535.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  command accepted this cycle when both cmd_valid and cmd_ready are high.
- cmd_encrypt  in  1  1 = encrypt, 0 = decrypt; sampled on command accept.
- cmd_newkey  in  1  1 = a 16-byte key precedes the block; sampled on command accept.
- in_valid  in  1  input byte present.
- in_ready  out  1  input byte accepted when both in_valid and in_ready are high.
- in_data  in  [0:7]  input byte.
- out_valid  out  1  output byte present.
- out_ready  in  1  output byte consumed when both out_valid and out_ready are high.
- out_data  out  [0:7]  output byte.
- key_o  out  [0:127]  key word to core.
- block_o  out  [0:127]  data block to core.
- sel_cypher  out  1  drives the core's selCypher input.
- key_change  out  1  drives the core's keyChange input.
- core_start  out  1  one-cycle start pulse to the core.
- core_done  in  1  core result valid, sampled each WAIT cycle.
- core_result  in  [0:127]  core output block.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag.

## Operation
- Byte order: byte n occupies bits [8n : 8n+7]; byte 0 is first on the wire (bits [0:7], MSB-first). This applies to input and output.
- 4-bit byte counter idx: cleared on entry to each LOAD/UNLOAD state; increments on each accepted or consumed byte; the state exits when idx = 15 and a byte transfers. idx never wraps inside a state.
- States and transitions:
  - IDLE: cmd_ready = 1. On command accept:
    - latch sel_cypher ← cmd_encrypt and key_change ← cmd_newkey;
    - clear err;
    - go to LOAD_KEY if cmd_newkey, else LOAD_BLK.
  - LOAD_KEY: in_ready = 1; an accepted byte is written to key_o byte idx. After byte 15, go to LOAD_BLK.
  - LOAD_BLK: in_ready = 1; an accepted byte is written to block_o byte idx. After byte 15, go to START.
  - START: core_start = 1 for exactly this cycle; clear the wait counter; go to WAIT.
  - WAIT: the wait counter increments each cycle.
    - If core_done = 1: capture core_result into the output register and go to UNLOAD. core_done takes priority over timeout in the same cycle.
    - Else if the counter reaches TIMEOUT − 1: set err = 1 and go to IDLE; no output is produced.
  - UNLOAD: out_valid = 1; out_data = output register byte idx. After byte 15 is consumed, go to IDLE.
- Without a new key, key_o keeps its previous value; key_change = 0 so the core reuses its stored round keys.
- sel_cypher, key_change, key_o and block_o are stable from START through the end of WAIT.
- in_valid is ignored outside the LOAD states; out_ready is ignored outside UNLOAD; cmd_valid is ignored outside IDLE.
- Reset (any state, including mid-transfer): state = IDLE, idx = 0, and all outputs go to 0 except cmd_ready = 1. This covers key_o, block_o, the output register, sel_cypher, key_change, core_start, out_valid, in_ready, busy and err.

## Timing
- All outputs are registered or decoded directly from state; there are no combinational paths from in_valid/out_ready to the ready/valid outputs.
- A command is accepted at edge t: LOAD state from t+1; in_ready is high from t+1.
- Last block byte accepted at edge t: core_start is high during cycle t+1.
- core_done sampled at edge t: out_valid is high, with byte 0, from t+1.
- Byte streams sustain one byte per cycle when the partner holds valid/ready high. Minimum total: 1 + 16 (key) + 16 (block) + 1 (start) + core latency + 16 (unload) cycles.
- Back-to-back commands: cmd_ready rises in the cycle after the last output byte is consumed.

## Test plan
- Encrypt with new key (FIPS-197): key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff; the core model returns 69c4e0d86a7b0430d8cdb78070b4c55a after 12 cycles. Required: sel_cypher = 1, key_change = 1, a single core_start pulse, and those 16 bytes output in order.
- Decrypt without new key, immediately following the first test: block 69c4…c55a. Required: key_o unchanged, key_change = 0, sel_cypher = 0, LOAD_KEY skipped (core_start exactly 17 cycles after command accept), output 00112233…eeff.
- Randomised in_valid/out_ready backpressure (≈50% duty). Required: identical key_o/block_o and output byte sequence; no byte duplicated or dropped; out_data held stable while out_valid & !out_ready.
- Core never asserts done, TIMEOUT = 8. Required: err = 1 exactly 8 cycles after START, return to IDLE with no out_valid; the next command accept clears err.
- core_done in the same cycle as the timeout threshold. Required: the result is captured, err stays 0, UNLOAD is entered.
- Reset asserted after 7 key bytes. Required: all outputs 0 except cmd_ready = 1; a fresh full command then completes correctly with idx restarting at 0.
